vdma_rd_burst_sched: RTL

//  Multi-channel AXI4 read-burst scheduler for the VDMA read path, in the axi_aclk domain.
//  Per channel: walks a 2-D frame (lines x beats, base + stride), cuts each line into bursts.

---
 rtl/vdma_rd_burst_sched_if.sv | 21 ++
 rtl/vdma_rd_burst_sched.sv | 136 +++++++++++++
 2 files changed

// File: rtl/vdma_rd_burst_sched_if.sv
// vdma_rd_burst_sched_if: AXI4 AR channel plus the R-side signals used for credit return
interface vdma_rd_burst_sched_if #(
  parameter int ASIZE  = 29,
  parameter int LSIZE  = 9,
  parameter int IDSIZE = 4
);
  logic [IDSIZE-1:0] arid;
  logic [ASIZE-1:0]  araddr;
  logic [LSIZE-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [IDSIZE-1:0] rid;
  logic              rvalid;
  logic              rready;
  modport master (output arid, araddr, arlen, arsize, arburst, arvalid,
                  input arready, rid, rvalid, rready);
  modport slave  (input arid, araddr, arlen, arsize, arburst, arvalid,
                  output arready, rid, rvalid, rready);
endinterface

// File: rtl/vdma_rd_burst_sched.sv
// vdma_rd_burst_sched: multi-channel 2-D frame walker with credit-gated round-robin AXI4 AR issue.
// Define VDMA_4K_SPLIT_EN to clip every burst at 4 KiB page boundaries.
module vdma_rd_burst_sched #(
  parameter int CH_NUM    = 2,
  parameter int ASIZE     = 29,
  parameter int LSIZE     = 9,
  parameter int IDSIZE    = 4,
  parameter int AXI_DSIZE = 256,
  parameter int BURST_LEN = 16,
  parameter int CSIZE     = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH_NUM-1:0]         ch_enable_i,
  input  logic [CH_NUM-1:0]         ch_fsync_i,
  input  logic [CH_NUM*ASIZE-1:0]   ch_base_addr_i,
  input  logic [CH_NUM*ASIZE-1:0]   ch_stride_i,
  input  logic [CH_NUM*16-1:0]      ch_line_beats_i,
  input  logic [CH_NUM*16-1:0]      ch_lines_i,
  input  logic [CH_NUM*CSIZE-1:0]   ch_fifo_space_i,
  output logic [CH_NUM-1:0]         ch_frame_done_o,
  vdma_rd_burst_sched_if.master     ar
);
  localparam int SZ  = $clog2(AXI_DSIZE/8);
  localparam int LW  = $clog2(BURST_LEN+1);
  localparam int CW  = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
  localparam int CW1 = CSIZE + 1;
  typedef enum logic {IDLE, ACTIVE} st_t;
  st_t               st_q     [CH_NUM];
  logic [ASIZE-1:0]  pbase_q  [CH_NUM];
  logic [ASIZE-1:0]  stride_q [CH_NUM];
  logic [ASIZE-1:0]  laddr_q  [CH_NUM];
  logic [15:0]       beats_q  [CH_NUM];
  logic [15:0]       lines_q  [CH_NUM];
  logic [15:0]       beat_q   [CH_NUM];
  logic [15:0]       line_q   [CH_NUM];
  logic [CSIZE-1:0]  out_q    [CH_NUM];
  logic [LW-1:0]     len_c    [CH_NUM];
  logic [ASIZE-1:0]  addr_c   [CH_NUM];
  logic [CH_NUM-1:0] pend_q, elig, on_ar, eol_c, last_c;
  logic [CW-1:0]     rr_q, gnt;
  logic              arvalid_q, last_q, gnt_v, hs, can_issue;
  logic [IDSIZE-1:0] arid_q;
  logic [ASIZE-1:0]  araddr_q;
  logic [LSIZE-1:0]  arlen_q;
  assign hs        = arvalid_q && ar.arready;
  assign can_issue = !arvalid_q || ar.arready;
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      on_ar[c]  = arvalid_q && arid_q == IDSIZE'(c);
      addr_c[c] = laddr_q[c] + (ASIZE'(beat_q[c]) << SZ);
      len_c[c]  = beats_q[c] - beat_q[c] < 16'(BURST_LEN) ? LW'(beats_q[c] - beat_q[c]) : LW'(BURST_LEN);
`ifdef VDMA_4K_SPLIT_EN
      if ((13'h1000 - {1'b0, addr_c[c][11:0]}) >> SZ < 13'(len_c[c]))
        len_c[c] = LW'((13'h1000 - {1'b0, addr_c[c][11:0]}) >> SZ);
`endif
      eol_c[c]  = beat_q[c] + 16'(len_c[c]) == beats_q[c];
      last_c[c] = eol_c[c] && line_q[c] + 16'd1 == lines_q[c];
      // a channel already on AR waits for its handshake so its credits are settled first
      elig[c]   = st_q[c] == ACTIVE && ch_enable_i[c] && !pend_q[c] && !ch_fsync_i[c] && !on_ar[c] &&
                  {1'b0, ch_fifo_space_i[c*CSIZE +: CSIZE]} >= {1'b0, out_q[c]} + CW1'(len_c[c]);
      ch_frame_done_o[c] = hs && on_ar[c] && last_q && !pend_q[c] && !ch_fsync_i[c];
    end
    gnt_v = 1'b0;
    gnt   = '0;
    for (int k = 0; k < CH_NUM; k++)
      if (!gnt_v && elig[(int'(rr_q) + k) % CH_NUM]) begin
        gnt_v = 1'b1;
        gnt   = CW'((int'(rr_q) + k) % CH_NUM);
      end
    gnt_v = gnt_v && can_issue;
  end
  // channel walk state advances at grant; the frame end is carried with the payload in last_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      last_q    <= 1'b0;
      rr_q      <= '0;
      pend_q    <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        st_q[c]     <= IDLE;
        pbase_q[c]  <= '0;
        stride_q[c] <= '0;
        laddr_q[c]  <= '0;
        beats_q[c]  <= '0;
        lines_q[c]  <= '0;
        beat_q[c]   <= '0;
        line_q[c]   <= '0;
        out_q[c]    <= '0;
      end
    end else begin
      if (can_issue) arvalid_q <= gnt_v;
      if (gnt_v) begin
        arid_q   <= IDSIZE'(gnt);
        araddr_q <= addr_c[gnt];
        arlen_q  <= LSIZE'(len_c[gnt] - LW'(1));
        last_q   <= last_c[gnt];
      end
      if (hs) rr_q <= CW'((int'(arid_q) + 1) % CH_NUM);
      for (int c = 0; c < CH_NUM; c++) begin
        out_q[c] <= out_q[c] + (hs && on_ar[c] ? CSIZE'(arlen_q) + CSIZE'(1) : '0)
                    - CSIZE'(ar.rvalid && ar.rready && ar.rid == IDSIZE'(c));
        if (ch_fsync_i[c]) begin
          pbase_q[c]  <= ch_base_addr_i[c*ASIZE +: ASIZE];
          stride_q[c] <= ch_stride_i[c*ASIZE +: ASIZE];
          beats_q[c]  <= ch_line_beats_i[c*16 +: 16];
          lines_q[c]  <= ch_lines_i[c*16 +: 16];
        end
        if (ch_fsync_i[c] && on_ar[c]) pend_q[c] <= 1'b1;
        else if (ch_fsync_i[c] || (pend_q[c] && !on_ar[c])) begin
          pend_q[c]  <= 1'b0;
          st_q[c]    <= ACTIVE;
          laddr_q[c] <= ch_fsync_i[c] ? ch_base_addr_i[c*ASIZE +: ASIZE] : pbase_q[c];
          beat_q[c]  <= '0;
          line_q[c]  <= '0;
        end else if (gnt_v && gnt == CW'(c)) begin
          beat_q[c] <= eol_c[c] ? '0 : beat_q[c] + 16'(len_c[c]);
          if (eol_c[c]) begin
            laddr_q[c] <= laddr_q[c] + stride_q[c];
            line_q[c]  <= line_q[c] + 16'd1;
          end
          if (last_c[c]) st_q[c] <= IDLE;
        end
      end
    end
  end
  assign ar.arvalid = arvalid_q;
  assign ar.arid    = arid_q;
  assign ar.araddr  = araddr_q;
  assign ar.arlen   = arlen_q;
  assign ar.arsize  = arvalid_q ? 3'(SZ) : 3'd0;
  assign ar.arburst = arvalid_q ? 2'b01 : 2'b00;
endmodule
